ram_rd_check: RTL and testbench
===============================

RAM_RD_CHECK -- requirements
Module: ram_rd_check

Interface
REQ-001 Parameter ADDR_W, default 6, address width; the block reads 2**ADDR_W words per pass.
REQ-002 Parameter DATA_W, default 8, read data width.
REQ-003 Parameter RD_LAT, default 1, RAM port-B read latency in clk cycles; legal values are 1 and 2.
REQ-004 Port clk, input, 1, single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 Port rd_flag, input, 1, level from the writer; a 0->1 transition requests one read pass.
REQ-007 Port ram_rd_en, output, 1, RAM port-B enable.
REQ-008 Port ram_rd_addr, output, ADDR_W, RAM port-B address.
REQ-009 Port ram_rd_data, input, DATA_W, RAM port-B read data, valid RD_LAT cycles after the en/addr cycle.
REQ-010 Port busy, output, 1, high while a pass is in progress.
REQ-011 Port done, output, 1, one-cycle pulse at the end of a pass.
REQ-012 Port pass_ok, output, 1, result of the last completed pass; 1 means zero mismatches.
REQ-013 Port err_cnt, output, ADDR_W+1, mismatch count of the current or last pass.

Function
REQ-014 The block SHALL register rd_flag and SHALL detect a rising edge as rd_flag=1 with the registered value =0.
REQ-015 The FSM SHALL have the states IDLE, READ, DRAIN and DONE.
REQ-016 IDLE: on a rising edge of rd_flag the FSM SHALL go to READ, clear err_cnt to 0, and set ram_rd_addr to 0.
REQ-017 READ: ram_rd_en SHALL be 1 and ram_rd_addr SHALL increment by 1 per cycle.
REQ-018 READ: at address 2**ADDR_W-1 the FSM SHALL go to DRAIN on the next cycle, with ram_rd_addr wrapping to 0.
REQ-019 Issue order: exactly 2**ADDR_W enable cycles per pass, with no gaps and no repeated address.
REQ-020 DRAIN: ram_rd_en SHALL be 0, and the FSM SHALL stay in DRAIN for RD_LAT cycles while in-flight data returns.
REQ-021 DRAIN exit: the FSM SHALL then go to DONE.
REQ-022 DONE: the block SHALL assert done for exactly 1 cycle, update pass_ok to (err_cnt==0) including any final-cycle increment, and return to IDLE.
REQ-023 Read tracking: a valid/address shift pipeline of depth RD_LAT SHALL track each issued read.
REQ-024 Compare rule: data is checked only in cycles where the delayed valid is 1.
REQ-025 Expected data SHALL be the issuing address zero-extended or truncated to DATA_W bits (the writer's pattern is data = address).
REQ-026 Each mismatch SHALL increment err_cnt by 1; the counter saturates at 2**ADDR_W, and saturation is unreachable in one pass.
REQ-027 busy SHALL be 1 in READ and DRAIN, and 0 in IDLE and DONE.
REQ-028 Rising edges of rd_flag that arrive while busy=1 or in DONE SHALL be ignored; they are not queued.
REQ-029 A rising edge of rd_flag in the same cycle that DONE returns to IDLE SHALL be ignored; a new pass needs a fresh 0->1 transition.
REQ-030 Outside READ, ram_rd_en SHALL be 0 and ram_rd_addr SHALL hold its value.
REQ-031 err_cnt and pass_ok SHALL hold their values between passes.

Reset
REQ-032 While rst_n=0 at a clock edge, the block SHALL enter IDLE.
REQ-033 Reset values: ram_rd_en=0, ram_rd_addr=0, busy=0, done=0, pass_ok=0, err_cnt=0, pipeline valids=0, and the registered rd_flag=0.
REQ-034 Reset during READ or DRAIN SHALL abort the pass with no done pulse, and in-flight returns SHALL be discarded.
REQ-035 If rd_flag is held at 1 through reset release, this SHALL count as a rising edge and start a pass on the first cycle after release.

Verification
REQ-036 RAM model holds mem[i]=i, RD_LAT=1, rd_flag 0->1 -> 64 consecutive en cycles with addresses 0..63, then done pulses 66 cycles after the edge, with pass_ok=1 and err_cnt=0.
REQ-037 Same as REQ-036 but with mem[5]=8'hFF and mem[63]=8'h00 -> err_cnt=2 and pass_ok=0 at done, including the error on the last word.
REQ-038 RD_LAT=2 with a correct RAM -> DRAIN lasts 2 cycles, done arrives 67 cycles after the edge, and pass_ok=1.
REQ-039 rd_flag toggled 0->1->0->1 during READ -> exactly one pass runs, with exactly one done pulse.
REQ-040 rst_n=0 for 1 cycle at address 30 of a pass -> no done pulse, all outputs at their reset values, and the next rd_flag edge runs a clean full pass.
REQ-041 rd_flag held at 1 across two back-to-back passes -> only one pass runs; a 1->0->1 sequence after done starts a second pass, and err_cnt is cleared at its start.

Source files
------------

// File: rtl/ram_rd_check_if.sv
// RAM port-B read bus between the read checker (master) and the RAM (slave).
interface ram_rd_check_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;

    modport master (output ram_rd_en, output ram_rd_addr, input ram_rd_data);
    modport slave  (input ram_rd_en, input ram_rd_addr, output ram_rd_data);
endinterface

// File: rtl/ram_rd_check.sv
// Reads every RAM word once per rd_flag rising edge and counts words whose
// data differs from the address pattern written by the writer.
module ram_rd_check #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_flag,
    ram_rd_check_if.master    ram,
    output logic              busy,
    output logic              done,
    output logic              pass_ok,
    output logic [ADDR_W:0]   err_cnt
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   ERR_MAX   = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic              rd_flag_q;
    logic              rd_rise;
    logic [1:0]        drain_cnt;
    logic [RD_LAT-1:0] pipe_v;
    logic [ADDR_W-1:0] pipe_a [RD_LAT];
    logic [DATA_W-1:0] exp_data;
    logic              mismatch;
    logic [ADDR_W:0]   err_next;

    // Last pipeline stage lines up with the returning read data.
    always_comb begin
        rd_rise  = rd_flag & ~rd_flag_q;
        exp_data = DATA_W'(pipe_a[RD_LAT-1]);
        mismatch = pipe_v[RD_LAT-1] && (ram.ram_rd_data != exp_data);
        err_next = err_cnt;
        if (mismatch && (err_cnt != ERR_MAX))
            err_next = err_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            rd_flag_q       <= 1'b0;
            ram.ram_rd_en   <= 1'b0;
            ram.ram_rd_addr <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass_ok         <= 1'b0;
            err_cnt         <= '0;
            drain_cnt       <= '0;
            pipe_v          <= '0;
        end else begin
            rd_flag_q <= rd_flag;
            done      <= 1'b0;
            err_cnt   <= err_next;
            pipe_v[0] <= ram.ram_rd_en;
            pipe_a[0] <= ram.ram_rd_addr;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end

            case (state)
                IDLE: begin
                    if (rd_rise) begin
                        state           <= READ;
                        ram.ram_rd_en   <= 1'b1;
                        ram.ram_rd_addr <= '0;
                        busy            <= 1'b1;
                        err_cnt         <= '0;
                    end
                end
                READ: begin
                    ram.ram_rd_addr <= ram.ram_rd_addr + 1'b1;
                    if (ram.ram_rd_addr == LAST_ADDR) begin
                        state         <= DRAIN;
                        ram.ram_rd_en <= 1'b0;
                        drain_cnt     <= 2'(RD_LAT - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    pass_ok <= (err_next == '0);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_rd_check.sv
// Directed bench: one checker with 1-cycle and one with 2-cycle RAM latency,
// driven by a shared rd_flag/rst_n and compared against hand-derived timing.
module tb_ram_rd_check;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_flag;
    logic       busy1, done1, ok1, busy2, done2, ok2;
    logic [6:0] err1, err2;
    logic [7:0] mem1 [64];
    logic [7:0] mem2 [64];
    logic [7:0] s2;
    int         errors;
    int         checks;

    always #5 clk = ~clk;

    ram_rd_check_if #(.ADDR_W(6), .DATA_W(8)) r1 ();
    ram_rd_check_if #(.ADDR_W(6), .DATA_W(8)) r2 ();

    ram_rd_check #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_flag(rd_flag), .ram(r1.master),
        .busy(busy1), .done(done1), .pass_ok(ok1), .err_cnt(err1)
    );
    ram_rd_check #(.ADDR_W(6), .DATA_W(8), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .rd_flag(rd_flag), .ram(r2.master),
        .busy(busy2), .done(done2), .pass_ok(ok2), .err_cnt(err2)
    );

    always @(posedge clk)
        if (r1.ram_rd_en) r1.ram_rd_data <= mem1[r1.ram_rd_addr];

    always @(posedge clk) begin
        if (r2.ram_rd_en) s2 <= mem2[r2.ram_rd_addr];
        r2.ram_rd_data <= s2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // k=0 is the first clock edge after the call; mode 0 plain, 1 flag toggle, 2 reset at addr 30
    task automatic observe(input string name, input int mode, input int exp_err);
        int         en_cnt[2], seq_bad[2], first_en[2], last_en[2];
        int         done_cnt[2], done_k[2], err_k0[2];
        logic       busy_rd[2], busy_dn[2], ok_dn[2], ok_end[2];
        logic [6:0] err_dn[2], err_end[2];
        logic       e[2], b[2], d[2], p[2];
        logic [5:0] a[2];
        logic [6:0] c[2];
        string      sfx;
        for (int u = 0; u < 2; u++) begin
            en_cnt[u] = 0; seq_bad[u] = 0; first_en[u] = -1; last_en[u] = -1;
            done_cnt[u] = 0; done_k[u] = -1; err_k0[u] = -1;
            busy_rd[u] = 1'bx; busy_dn[u] = 1'bx; ok_dn[u] = 1'bx; err_dn[u] = 'x;
        end
        for (int k = 0; k < 120; k++) begin
            @(posedge clk); #1;
            e[0] = r1.ram_rd_en; a[0] = r1.ram_rd_addr; b[0] = busy1; d[0] = done1; p[0] = ok1; c[0] = err1;
            e[1] = r2.ram_rd_en; a[1] = r2.ram_rd_addr; b[1] = busy2; d[1] = done2; p[1] = ok2; c[1] = err2;
            for (int u = 0; u < 2; u++) begin
                if (e[u]) begin
                    if (a[u] != 6'(en_cnt[u])) seq_bad[u]++;
                    if (first_en[u] < 0) first_en[u] = k;
                    last_en[u] = k;
                    en_cnt[u]++;
                end
                if (d[u]) begin
                    done_cnt[u]++;
                    if (done_k[u] < 0) begin
                        done_k[u] = k; ok_dn[u] = p[u]; err_dn[u] = c[u];
                    end
                end
                if (k == 0) err_k0[u] = c[u];
                if (k == 63) busy_rd[u] = b[u];
                if (k == 65 + u) busy_dn[u] = b[u];
                ok_end[u] = p[u];
                err_end[u] = c[u];
            end
            if (mode == 1 && k == 10) rd_flag = 1'b0;
            if (mode == 1 && k == 12) rd_flag = 1'b1;
            if (mode == 2 && k == 30) begin
                chk({name, " addr_at_abort"}, a[0], 30);
                rst_n = 1'b0;
                rd_flag = 1'b0;
            end
            if (mode == 2 && k == 31) begin
                for (int u = 0; u < 2; u++) begin
                    sfx = (u == 0) ? " lat1" : " lat2";
                    chk({name, " rst_en", sfx}, e[u], 0);
                    chk({name, " rst_addr", sfx}, a[u], 0);
                    chk({name, " rst_busy", sfx}, b[u], 0);
                    chk({name, " rst_done", sfx}, d[u], 0);
                    chk({name, " rst_pass_ok", sfx}, p[u], 0);
                    chk({name, " rst_err_cnt", sfx}, c[u], 0);
                end
                rst_n = 1'b1;
            end
        end
        for (int u = 0; u < 2; u++) begin
            sfx = (u == 0) ? " lat1" : " lat2";
            if (mode == 2) begin
                chk({name, " en_cycles", sfx}, en_cnt[u], 31);
                chk({name, " done_pulses", sfx}, done_cnt[u], 0);
            end else begin
                chk({name, " en_cycles", sfx}, en_cnt[u], 64);
                chk({name, " addr_seq_bad", sfx}, seq_bad[u], 0);
                chk({name, " first_en", sfx}, first_en[u], 0);
                chk({name, " last_en", sfx}, last_en[u], 63);
                chk({name, " err_cleared", sfx}, err_k0[u], 0);
                chk({name, " busy_read", sfx}, busy_rd[u], 1);
                chk({name, " busy_done", sfx}, busy_dn[u], 0);
                chk({name, " done_pulses", sfx}, done_cnt[u], 1);
                chk({name, " done_cycle", sfx}, done_k[u], 66 + u);
                chk({name, " pass_ok", sfx}, ok_dn[u], (exp_err == 0));
                chk({name, " err_cnt", sfx}, err_dn[u], exp_err);
                chk({name, " err_hold", sfx}, err_end[u], exp_err);
                chk({name, " ok_hold", sfx}, ok_end[u], (exp_err == 0));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        rd_flag = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem1[i] = 8'(i);
            mem2[i] = 8'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset en lat1", r1.ram_rd_en, 0);
        chk("reset addr lat1", r1.ram_rd_addr, 0);
        chk("reset busy lat1", busy1, 0);
        chk("reset done lat1", done1, 0);
        chk("reset pass_ok lat1", ok1, 0);
        chk("reset err_cnt lat1", err1, 0);
        chk("reset en lat2", r2.ram_rd_en, 0);
        chk("reset addr lat2", r2.ram_rd_addr, 0);
        chk("reset busy lat2", busy2, 0);
        chk("reset done lat2", done2, 0);
        chk("reset pass_ok lat2", ok2, 0);
        chk("reset err_cnt lat2", err2, 0);

        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle en lat1", r1.ram_rd_en, 0);
        chk("idle busy lat2", busy2, 0);

        // clean pass; rd_flag stays high afterwards, so no second pass may start
        rd_flag = 1'b1;
        observe("clean", 0, 0);

        mem1[5] = 8'hFF; mem1[63] = 8'h00;
        mem2[5] = 8'hFF; mem2[63] = 8'h00;
        rd_flag = 1'b0;
        @(posedge clk); #1;
        rd_flag = 1'b1;
        observe("corrupt", 0, 2);

        mem1[5] = 8'd5; mem1[63] = 8'd63;
        mem2[5] = 8'd5; mem2[63] = 8'd63;
        rd_flag = 1'b0;
        @(posedge clk); #1;
        rd_flag = 1'b1;
        observe("toggle", 1, 0);

        rd_flag = 1'b0;
        @(posedge clk); #1;
        rd_flag = 1'b1;
        observe("abort", 2, 0);

        rd_flag = 1'b1;
        observe("after_abort", 0, 0);

        // rd_flag still high across a reset pulse starts a pass right after release
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        observe("flag_thru_reset", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
